exception_ctrl: RTL and testbench

Owns the CP0 exception/interrupt state (Status, Cause, EPC, BadVAddr, Count, Compare) and sequences exception entry and ERET for the pipeline. It sits beside the MEM stage:
- takes the per-instruction exception decision and ERET requests;
- commits CP0 updates, flushes and stalls the pipeline for a fixed window;
- hands a redirect PC to fetch with a valid/ready handshake;
- synchronises external interrupts and runs the Count/Compare timer to raise a pending-interrupt flag back to the exception detector.

---
 rtl/cp0_pkg.sv | 34 +++
 rtl/int_sync.sv | 22 ++
 rtl/exception_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_exception_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, Status/Cause bit positions,
// exception codes and the exception sequencer state encoding.
package cp0_pkg;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  localparam int STATUS_IE  = 0;
  localparam int STATUS_EXL = 1;
  localparam int STATUS_BEV = 22;
  localparam int CAUSE_TI   = 30;
  localparam int CAUSE_BD   = 31;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

  typedef enum logic [1:0] {
    IDLE,
    FLUSH,
    REDIRECT
  } state_t;

endpackage

// File: rtl/int_sync.sv
// Multi-stage synchroniser for one asynchronous interrupt line.
module int_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) chain <= '0;
    else     chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/exception_ctrl.sv
// CP0 exception/interrupt state plus the exception-entry / ERET sequencer
// that flushes, stalls and redirects the pipeline.
module exception_ctrl
  import cp0_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEFAULT,
  parameter int          FLUSH_CYCLES = 2,
  parameter int          SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_req,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic        exc_is_ds,
  input  logic        exc_bad_we,
  input  logic [31:0] exc_badvaddr,
  input  logic        eret_req,
  input  logic [5:0]  hw_int,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_waddr,
  input  logic [31:0] cp0_wdata,
  input  logic [4:0]  cp0_raddr,
  output logic [31:0] cp0_rdata,
  output logic        int_pending,
  output logic        flush,
  output logic        stall,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready
);

  state_t      state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic [31:0] target_pc, target_next;

  logic [7:0]  im;
  logic        exl, ie;
  logic        bd, ti;
  logic [1:0]  ip_sw;
  logic [5:0]  ip_hw;
  logic [4:0]  exc_code_q;
  logic [31:0] epc, badvaddr, count, compare;
  logic        tick;
  logic [5:0]  hw_sync;

  logic        take_exc, take_eret;
  logic        count_we, compare_we, count_match;
  logic [31:0] count_next;
  logic [7:0]  ip_full;
  logic [31:0] status_rd, cause_rd;

  for (genvar i = 0; i < 6; i++) begin : g_sync
    int_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (hw_int[i]),
      .q   (hw_sync[i])
    );
  end

  assign take_exc  = (state == IDLE) && exc_req;
  assign take_eret = (state == IDLE) && eret_req && !exc_req;

  // ---------------- sequencer ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      target_pc <= '0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      target_pc <= target_next;
    end
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    target_next    = target_pc;
    flush          = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    unique case (state)
      IDLE: begin
        if (take_exc || take_eret) begin
          state_next  = FLUSH;
          cnt_next    = 4'(FLUSH_CYCLES);
          target_next = take_exc ? EXC_VECTOR : epc;
        end
      end
      FLUSH: begin
        flush    = 1'b1;
        stall    = 1'b1;
        cnt_next = cnt - 4'd1;
        if (cnt == 4'd1) state_next = REDIRECT;
      end
      REDIRECT: begin
        stall          = 1'b1;
        redirect_valid = 1'b1;
        if (redirect_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign redirect_pc = target_pc;

  // ---------------- timer ----------------
  assign count_we    = cp0_we && (cp0_waddr == CP0_COUNT);
  assign compare_we  = cp0_we && (cp0_waddr == CP0_COMPARE);
  assign count_next  = count_we ? cp0_wdata : (tick ? count + 32'd1 : count);
  assign count_match = tick && !count_we && (count + 32'd1 == compare);

  // ---------------- CP0 registers ----------------
  // MTC0 effects are scheduled first; the commit/ERET assignments that follow
  // override only the fields they own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      im         <= '0;
      exl        <= 1'b0;
      ie         <= 1'b0;
      bd         <= 1'b0;
      ti         <= 1'b0;
      ip_sw      <= '0;
      ip_hw      <= '0;
      exc_code_q <= '0;
      epc        <= '0;
      badvaddr   <= '0;
      count      <= '0;
      compare    <= '0;
      tick       <= 1'b0;
    end else begin
      tick  <= ~tick;
      ip_hw <= hw_sync;
      count <= count_next;

      if (cp0_we) begin
        case (cp0_waddr)
          CP0_COMPARE: compare <= cp0_wdata;
          CP0_STATUS: begin
            im  <= cp0_wdata[15:8];
            exl <= cp0_wdata[STATUS_EXL];
            ie  <= cp0_wdata[STATUS_IE];
          end
          CP0_CAUSE:   ip_sw <= cp0_wdata[9:8];
          CP0_EPC:     epc   <= cp0_wdata;
          default: ;
        endcase
      end

      if (compare_we)       ti <= 1'b0;
      else if (count_match) ti <= 1'b1;

      if (take_exc) begin
        if (!exl) begin
          epc <= exc_is_ds ? exc_pc - 32'd4 : exc_pc;
          bd  <= exc_is_ds;
        end
        exc_code_q <= exc_code;
        exl        <= 1'b1;
        if (exc_bad_we) badvaddr <= exc_badvaddr;
      end else if (take_eret) begin
        exl <= 1'b0;
      end
    end
  end

  assign ip_full     = {ip_hw[5] | ti, ip_hw[4:0], ip_sw};
  assign int_pending = ie & ~exl & (|(ip_full & im)) & (state == IDLE);

  always_comb begin
    status_rd             = '0;
    status_rd[STATUS_BEV] = 1'b1;
    status_rd[15:8]       = im;
    status_rd[STATUS_EXL] = exl;
    status_rd[STATUS_IE]  = ie;

    cause_rd           = '0;
    cause_rd[CAUSE_BD] = bd;
    cause_rd[CAUSE_TI] = ti;
    cause_rd[15:8]     = ip_full;
    cause_rd[6:2]      = exc_code_q;

    case (cp0_raddr)
      CP0_BADVADDR: cp0_rdata = badvaddr;
      CP0_COUNT:    cp0_rdata = count;
      CP0_COMPARE:  cp0_rdata = compare;
      CP0_STATUS:   cp0_rdata = status_rd;
      CP0_CAUSE:    cp0_rdata = cause_rd;
      CP0_EPC:      cp0_rdata = epc;
      default:      cp0_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_exception_ctrl.sv
// Scoreboard bench for exception_ctrl: stimulus queues expectations, monitors
// compare them against what the DUT presents.
module tb_exception_ctrl;
  import cp0_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        exc_req, exc_is_ds, exc_bad_we, eret_req;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc, exc_badvaddr;
  logic [5:0]  hw_int;
  logic        cp0_we;
  logic [4:0]  cp0_waddr, cp0_raddr;
  logic [31:0] cp0_wdata, cp0_rdata;
  logic        int_pending, flush, stall, redirect_valid, redirect_ready;
  logic [31:0] redirect_pc;

  always #5 clk = ~clk;

  exception_ctrl #(
    .EXC_VECTOR  (32'hBFC0_0380),
    .FLUSH_CYCLES(2),
    .SYNC_STAGES (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .exc_req       (exc_req),
    .exc_code      (exc_code),
    .exc_pc        (exc_pc),
    .exc_is_ds     (exc_is_ds),
    .exc_bad_we    (exc_bad_we),
    .exc_badvaddr  (exc_badvaddr),
    .eret_req      (eret_req),
    .hw_int        (hw_int),
    .cp0_we        (cp0_we),
    .cp0_waddr     (cp0_waddr),
    .cp0_wdata     (cp0_wdata),
    .cp0_raddr     (cp0_raddr),
    .cp0_rdata     (cp0_rdata),
    .int_pending   (int_pending),
    .flush         (flush),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .redirect_ready(redirect_ready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // kind 0: cp0_rdata, kind 1: {flush,stall,redirect_valid,int_pending}, kind 2: redirect_pc
  int          kind_q[$];
  logic [31:0] exp_q[$];
  string       name_q[$];
  logic [31:0] redir_q[$];

  localparam logic [31:0] SIG_IDLE   = 32'h0;
  localparam logic [31:0] SIG_INT    = 32'h1;
  localparam logic [31:0] SIG_REDIR  = 32'h6;
  localparam logic [31:0] SIG_FLUSH  = 32'hC;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Register/status sampling monitor.
  always @(negedge clk) begin
    while (kind_q.size() > 0) begin
      int          k;
      logic [31:0] e;
      string       nm;
      logic [31:0] act;
      k  = kind_q.pop_front();
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      case (k)
        0:       act = cp0_rdata;
        1:       act = {28'b0, flush, stall, redirect_valid, int_pending};
        default: act = redirect_pc;
      endcase
      check(nm, act, e);
    end
  end

  // Redirect handshake monitor.
  logic        held = 1'b0;
  logic [31:0] held_pc;
  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0;
    end else if (redirect_valid) begin
      if (held) check("redirect_pc_stable", redirect_pc, held_pc);
      held    = 1'b1;
      held_pc = redirect_pc;
      if (redirect_ready) begin
        if (redir_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_redirect: got %h expected none", redirect_pc);
        end else begin
          check("redirect_pc", redirect_pc, redir_q.pop_front());
        end
        held = 1'b0;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_rd(input logic [4:0] addr, input logic [31:0] exp, input string name);
    cp0_raddr = addr;
    kind_q.push_back(0); exp_q.push_back(exp); name_q.push_back(name);
  endtask

  task automatic expect_sig(input logic [31:0] exp, input string name);
    kind_q.push_back(1); exp_q.push_back(exp); name_q.push_back(name);
  endtask

  task automatic expect_rpc(input logic [31:0] exp, input string name);
    kind_q.push_back(2); exp_q.push_back(exp); name_q.push_back(name);
  endtask

  task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
    cp0_we = 1'b1; cp0_waddr = addr; cp0_wdata = data;
    cyc();
    cp0_we = 1'b0;
  endtask

  initial begin
    #200_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int  waited;
    bit  found;

    rst = 1'b1;
    exc_req = 0; exc_code = 0; exc_pc = 0; exc_is_ds = 0; exc_bad_we = 0;
    exc_badvaddr = 0; eret_req = 0; hw_int = 0; cp0_we = 0; cp0_waddr = 0;
    cp0_wdata = 0; cp0_raddr = 0; redirect_ready = 0;
    repeat (3) cyc();
    rst = 1'b0;

    // Reset state
    expect_sig(SIG_IDLE, "reset_sig"); expect_rd(CP0_STATUS, 32'h0040_0000, "reset_status"); cyc();
    expect_rpc(32'h0, "reset_rpc");    expect_rd(CP0_CAUSE, 32'h0, "reset_cause");          cyc();
    expect_rd(CP0_EPC, 32'h0, "reset_epc"); cyc();

    // Exception in a delay slot
    exc_req = 1; exc_code = EXC_SYS; exc_pc = 32'h8000_0104; exc_is_ds = 1;
    exc_bad_we = 1; exc_badvaddr = 32'hDEAD_BEEF;
    redir_q.push_back(32'hBFC0_0380);
    cyc();
    exc_req = 0; exc_bad_we = 0;
    expect_sig(SIG_FLUSH, "exc_flush1"); expect_rd(CP0_EPC, 32'h8000_0100, "exc_epc"); cyc();
    expect_sig(SIG_FLUSH, "exc_flush2"); expect_rd(CP0_CAUSE, 32'h8000_0020, "exc_cause"); cyc();
    expect_sig(SIG_REDIR, "exc_redir_wait1"); expect_rd(CP0_STATUS, 32'h0040_0002, "exc_status"); cyc();
    expect_sig(SIG_REDIR, "exc_redir_wait2"); expect_rd(CP0_BADVADDR, 32'hDEAD_BEEF, "exc_badvaddr"); cyc();
    expect_sig(SIG_REDIR, "exc_redir_wait3"); expect_rpc(32'hBFC0_0380, "exc_rpc_hold"); cyc();
    redirect_ready = 1;
    expect_sig(SIG_REDIR, "exc_redir_accept"); cyc();
    redirect_ready = 0;
    expect_sig(SIG_IDLE, "exc_back_idle"); cyc();

    // ERET to EPC; an exc_req during FLUSH must be ignored
    mtc0(CP0_EPC, 32'h8000_2000);
    eret_req = 1;
    redir_q.push_back(32'h8000_2000);
    cyc();
    eret_req = 0;
    exc_req = 1; exc_code = EXC_OV; exc_pc = 32'h1234_0000; exc_is_ds = 0;
    expect_sig(SIG_FLUSH, "eret_flush1"); expect_rd(CP0_STATUS, 32'h0040_0000, "eret_exl_clear"); cyc();
    exc_req = 0;
    expect_sig(SIG_FLUSH, "eret_flush2"); cyc();
    redirect_ready = 1;
    expect_sig(SIG_REDIR, "eret_redir"); cyc();
    redirect_ready = 0;
    expect_sig(SIG_IDLE, "eret_idle"); expect_rd(CP0_CAUSE, 32'h8000_0020, "exc_ignored_in_flush"); cyc();
    expect_rd(CP0_EPC, 32'h8000_2000, "epc_kept"); cyc();

    // Timer interrupt
    mtc0(CP0_STATUS, 32'h0000_8001);
    mtc0(CP0_COMPARE, 32'd10);
    mtc0(CP0_COUNT, 32'd0);
    cp0_raddr = CP0_CAUSE;
    waited = 0; found = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      waited++;
      if (cp0_rdata[CAUSE_TI]) begin
        found = 1;
        break;
      end
    end
    check("ti_set_in_window", {31'b0, found && waited >= 18 && waited <= 21}, 32'd1);
    expect_sig(SIG_INT, "timer_int_pending"); expect_rd(CP0_CAUSE, 32'hC000_8020, "timer_cause"); cyc();
    mtc0(CP0_COMPARE, 32'hFFFF_0000);
    expect_sig(SIG_IDLE, "ti_cleared_sig"); expect_rd(CP0_CAUSE, 32'h8000_0020, "ti_cleared_cause"); cyc();

    // hw_int latency: SYNC_STAGES + 1 cycles
    mtc0(CP0_STATUS, 32'h0000_0401);
    hw_int = 6'b000001;
    expect_sig(SIG_IDLE, "hwint_lat0"); cyc();
    expect_sig(SIG_IDLE, "hwint_lat1"); cyc();
    expect_sig(SIG_IDLE, "hwint_lat2"); cyc();
    expect_sig(SIG_INT,  "hwint_lat3"); expect_rd(CP0_CAUSE, 32'h8000_0420, "hwint_cause"); cyc();
    hw_int = 6'b0;
    repeat (4) cyc();

    // exc_req + eret_req + MTC0 EPC in one cycle: exception wins
    exc_req = 1; eret_req = 1; exc_code = EXC_ADEL; exc_pc = 32'h8000_0300; exc_is_ds = 0;
    cp0_we = 1; cp0_waddr = CP0_EPC; cp0_wdata = 32'h1234_5678;
    redir_q.push_back(32'hBFC0_0380);
    cyc();
    exc_req = 0; eret_req = 0; cp0_we = 0;
    expect_sig(SIG_FLUSH, "both_flush1"); expect_rd(CP0_EPC, 32'h8000_0300, "both_epc"); cyc();
    expect_sig(SIG_FLUSH, "both_flush2"); expect_rd(CP0_CAUSE, 32'h0000_0010, "both_cause"); cyc();
    redirect_ready = 1;
    expect_sig(SIG_REDIR, "both_redir"); cyc();
    redirect_ready = 0;
    expect_sig(SIG_IDLE, "both_idle"); expect_rd(CP0_STATUS, 32'h0040_0403, "both_status"); cyc();

    // Reset during REDIRECT
    exc_req = 1; exc_code = EXC_BP; exc_pc = 32'h8000_0400;
    cyc();
    exc_req = 0;
    cyc(); cyc();
    expect_sig(SIG_REDIR, "rst_pre_redir"); cyc();
    #1 rst = 1'b1;
    expect_sig(SIG_IDLE, "rst_async_sig"); expect_rpc(32'h0, "rst_async_rpc");
    expect_rd(CP0_STATUS, 32'h0040_0000, "rst_async_status");
    cyc();
    cyc();
    rst = 1'b0;
    redirect_ready = 1;
    expect_sig(SIG_IDLE, "post_rst_idle1"); expect_rd(CP0_EPC, 32'h0, "post_rst_epc"); cyc();
    expect_sig(SIG_IDLE, "post_rst_idle2"); cyc();
    redirect_ready = 0;
    cyc();

    check("redirects_all_seen", 32'(redir_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
